// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, word-addressed data RAM, branch resolve and a wait-state FSM for slow memory.
// Optional misaligned-access checking is enabled with `define MEM_ALIGN_CHECK_EN.
module mem_stage #(
   parameter int DEPTH_LOG2 = 5,
   parameter int MEM_LAT    = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_wreg,
   input  logic        ex_m2reg,
   input  logic        ex_wmem,
   input  logic [31:0] ex_aluR,
   input  logic [31:0] ex_inB,
   input  logic [4:0]  ex_destR,
   input  logic        ex_branch,
   input  logic [31:0] ex_pc,
   input  logic        ex_zero,
   input  logic [3:0]  EXE_ins_type,
   input  logic [3:0]  EXE_ins_number,
   output logic        mem_wreg,
   output logic        mem_m2reg,
   output logic [31:0] mem_aluR,
   output logic [31:0] mem_mdata,
   output logic [4:0]  mem_destR,
   output logic        mem_pcsrc,
   output logic [31:0] mem_bpc,
   output logic        mem_stall,
   output logic        mem_addr_err,
   output logic [3:0]  MEM_ins_type,
   output logic [3:0]  MEM_ins_number
);

   localparam int LAT_M1 = (MEM_LAT > 0) ? MEM_LAT - 1 : 0;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      r_state, w_state_nx;
   logic [3:0]  r_cnt, w_cnt_nx;
   logic        w_stall;
   logic        w_mis;
   logic        w_memop;

   logic        r_wreg, r_m2reg, r_wmem, r_branch, r_zero;
   logic [31:0] r_aluR, r_inB, r_pc;
   logic [4:0]  r_destR;
   logic [3:0]  r_type, r_num;

   logic [31:0] r_ram [2**DEPTH_LOG2];
   logic [DEPTH_LOG2-1:0] w_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wreg   <= 1'b0;
         r_m2reg  <= 1'b0;
         r_wmem   <= 1'b0;
         r_aluR   <= '0;
         r_inB    <= '0;
         r_destR  <= '0;
         r_branch <= 1'b0;
         r_pc     <= '0;
         r_zero   <= 1'b0;
         r_type   <= '0;
         r_num    <= '0;
      end else if (!mem_stall) begin
         r_wreg   <= ex_wreg;
         r_m2reg  <= ex_m2reg;
         r_wmem   <= ex_wmem;
         r_aluR   <= ex_aluR;
         r_inB    <= ex_inB;
         r_destR  <= ex_destR;
         r_branch <= ex_branch;
         r_pc     <= ex_pc;
         r_zero   <= ex_zero;
         r_type   <= EXE_ins_type;
         r_num    <= EXE_ins_number;
      end
   end

`ifdef MEM_ALIGN_CHECK_EN
   assign w_mis = (r_m2reg | r_wmem) & (r_aluR[1:0] != 2'b00);
`else
   assign w_mis = 1'b0;
`endif

   // Misaligned ops never touch memory, so they neither stall nor write.
   assign w_memop = (r_m2reg | r_wmem) & ~w_mis;

   // The WAIT cycle that sees cnt==0 is the completing cycle: the stall drops
   // and the EX/MEM register loads the next op at its closing edge.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_stall    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_memop && (MEM_LAT > 0)) begin
               w_stall    = 1'b1;
               w_cnt_nx   = 4'(LAT_M1);
               w_state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nx = S_IDLE;
            end else begin
               w_stall  = 1'b1;
               w_cnt_nx = r_cnt - 4'd1;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   assign w_idx = r_aluR[DEPTH_LOG2+1:2];

   always_ff @(posedge clk) begin
      if (!rst && r_wmem && !w_mis && !w_stall)
         r_ram[w_idx] <= r_inB;
   end

   assign mem_stall      = w_stall & ~rst;
   assign mem_wreg       = r_wreg & ~(r_m2reg & w_mis);
   assign mem_m2reg      = r_m2reg;
   assign mem_aluR       = r_aluR;
   assign mem_mdata      = r_ram[w_idx];
   assign mem_destR      = r_destR;
   assign mem_pcsrc      = r_branch & r_zero;
   assign mem_bpc        = r_pc;
   assign mem_addr_err   = w_mis;
   assign MEM_ins_type   = r_type;
   assign MEM_ins_number = r_num;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a MEM_LAT=0 and a MEM_LAT=3 instance, each checked every cycle
// against a transaction-level model, plus a directed vector table and stall/reset sequences.
module tb_mem_stage;

`ifdef MEM_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct packed {
      logic        wreg, m2reg, wmem, branch, zero;
      logic [31:0] aluR, inB, pc;
      logic [4:0]  destR;
      logic [3:0]  typ, num;
   } in_t;

   typedef struct packed {
      logic        wreg, m2reg, pcsrc, stall, err;
      logic [31:0] aluR, mdata, bpc;
      logic [4:0]  destR;
      logic [3:0]  typ, num;
   } out_t;

   typedef struct {
      in_t         in;
      bit          chk_md;
      logic [31:0] md;
      logic        wreg, m2reg, pcsrc, err;
      logic [31:0] bpc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   in_t  di [2];
   out_t o  [2];

   int nvec = 0;
   int nfail = 0;

   // model state: registered op, cycles since capture, RAM image with known-valid bits
   in_t         mop  [2];
   int          mage [2];
   logic [31:0] mram [2][32];
   bit          mval [2][32];

   always #5 clk = ~clk;

   logic        w0_wreg, w0_m2reg, w0_pcsrc, w0_stall, w0_err, w3_wreg, w3_m2reg, w3_pcsrc, w3_stall, w3_err;
   logic [31:0] w0_aluR, w0_mdata, w0_bpc, w3_aluR, w3_mdata, w3_bpc;
   logic [4:0]  w0_destR, w3_destR;
   logic [3:0]  w0_typ, w0_num, w3_typ, w3_num;

   mem_stage #(.DEPTH_LOG2(5), .MEM_LAT(0)) u0 (
      .clk(clk), .rst(rst),
      .ex_wreg(di[0].wreg), .ex_m2reg(di[0].m2reg), .ex_wmem(di[0].wmem), .ex_aluR(di[0].aluR),
      .ex_inB(di[0].inB), .ex_destR(di[0].destR), .ex_branch(di[0].branch), .ex_pc(di[0].pc),
      .ex_zero(di[0].zero), .EXE_ins_type(di[0].typ), .EXE_ins_number(di[0].num),
      .mem_wreg(w0_wreg), .mem_m2reg(w0_m2reg), .mem_aluR(w0_aluR), .mem_mdata(w0_mdata),
      .mem_destR(w0_destR), .mem_pcsrc(w0_pcsrc), .mem_bpc(w0_bpc), .mem_stall(w0_stall),
      .mem_addr_err(w0_err), .MEM_ins_type(w0_typ), .MEM_ins_number(w0_num));

   mem_stage #(.DEPTH_LOG2(5), .MEM_LAT(3)) u3 (
      .clk(clk), .rst(rst),
      .ex_wreg(di[1].wreg), .ex_m2reg(di[1].m2reg), .ex_wmem(di[1].wmem), .ex_aluR(di[1].aluR),
      .ex_inB(di[1].inB), .ex_destR(di[1].destR), .ex_branch(di[1].branch), .ex_pc(di[1].pc),
      .ex_zero(di[1].zero), .EXE_ins_type(di[1].typ), .EXE_ins_number(di[1].num),
      .mem_wreg(w3_wreg), .mem_m2reg(w3_m2reg), .mem_aluR(w3_aluR), .mem_mdata(w3_mdata),
      .mem_destR(w3_destR), .mem_pcsrc(w3_pcsrc), .mem_bpc(w3_bpc), .mem_stall(w3_stall),
      .mem_addr_err(w3_err), .MEM_ins_type(w3_typ), .MEM_ins_number(w3_num));

   always_comb begin
      o[0] = '{wreg:w0_wreg, m2reg:w0_m2reg, pcsrc:w0_pcsrc, stall:w0_stall, err:w0_err,
               aluR:w0_aluR, mdata:w0_mdata, bpc:w0_bpc, destR:w0_destR, typ:w0_typ, num:w0_num};
      o[1] = '{wreg:w3_wreg, m2reg:w3_m2reg, pcsrc:w3_pcsrc, stall:w3_stall, err:w3_err,
               aluR:w3_aluR, mdata:w3_mdata, bpc:w3_bpc, destR:w3_destR, typ:w3_typ, num:w3_num};
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   function automatic int lat(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic bit mis(input int d);
      return ALIGN && (mop[d].m2reg || mop[d].wmem) && (mop[d].aluR[1:0] != 2'b00);
   endfunction

   // A memory op stalls until it has been registered for MEM_LAT cycles.
   function automatic bit busy(input int d);
      return (mop[d].m2reg || mop[d].wmem) && !mis(d) && (mage[d] < lat(d));
   endfunction

   task automatic cmp(input int d);
      in_t        p;
      bit         es, mi;
      logic [4:0] ix;
      p  = mop[d];
      mi = mis(d);
      es = busy(d) && !rst;
      ix = p.aluR[6:2];
      chk($sformatf("d%0d_ctl", d),
          {14'd0, o[d].wreg, o[d].m2reg, o[d].stall, o[d].pcsrc, o[d].err, o[d].destR, o[d].typ, o[d].num},
          {14'd0, p.wreg && !(mi && p.m2reg), p.m2reg, es, p.branch && p.zero, mi, p.destR, p.typ, p.num});
      chk($sformatf("d%0d_aluR", d), o[d].aluR, p.aluR);
      chk($sformatf("d%0d_bpc", d), o[d].bpc, p.pc);
      if (mval[d][ix] && !es) chk($sformatf("d%0d_mdata", d), o[d].mdata, mram[d][ix]);
   endtask

   task automatic step();
      in_t s [2];
      bit  r;
      bit  st [2];
      s = di;
      r = rst;
      for (int d = 0; d < 2; d++) st[d] = busy(d);
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (r) begin
            mop[d]  = '0;
            mage[d] = 0;
         end else if (!st[d]) begin
            if (mop[d].wmem && !mis(d)) begin
               mram[d][mop[d].aluR[6:2]] = mop[d].inB;
               mval[d][mop[d].aluR[6:2]] = 1'b1;
            end
            mop[d]  = s[d];
            mage[d] = 0;
         end else begin
            mage[d]++;
         end
      end
      #1;
      cmp(0);
      cmp(1);
   endtask

   function automatic in_t mk(input bit wr, m2, wm, br, z, input logic [31:0] a, b, pc,
                              input logic [4:0] dr, input logic [3:0] t, n);
      in_t x;
      x = '{wreg:wr, m2reg:m2, wmem:wm, branch:br, zero:z, aluR:a, inB:b, pc:pc, destR:dr, typ:t, num:n};
      return x;
   endfunction

   function automatic in_t rnd();
      in_t         x;
      int          k;
      logic [31:0] a;
      k = $urandom_range(0, 3);
      a = {22'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0) a[9:8] = 2'($urandom_range(1, 3));
      x = mk(k == 0 || k == 1, k == 1, k == 2, k == 3, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom, 5'($urandom), 4'($urandom), 4'($urandom));
      return x;
   endfunction

   // Steps the MEM_LAT=3 instance until its stall drops; returns the number of stalled cycles seen.
   task automatic wait_done(output int n);
      n = 0;
      for (int k = 0; k < 20 && o[1].stall; k++) begin
         n++;
         step();
      end
      if (o[1].stall) begin
         nvec++;
         nfail++;
         $display("FAIL stall_timeout: stall still 1 after 20 cycles, required 0");
      end
   endtask

   vec_t tab [11];
   int   n;

   initial begin
      for (int d = 0; d < 2; d++) begin
         di[d] = '0;
         mop[d] = '0;
         mage[d] = 0;
         for (int i = 0; i < 32; i++) mval[d][i] = 1'b0;
      end

      tab[0]  = '{mk(0,0,1,0,0, 32'h08, 32'hDEADBEEF, 0, 0, 1, 1), 0, 0, 0, 0, 0, 0, 0};
      tab[1]  = '{mk(1,1,0,0,0, 32'h08, 0, 0, 3, 2, 2), 1, 32'hDEADBEEF, 1, 1, 0, 0, 0};
      tab[2]  = '{mk(0,0,0,1,1, 0, 0, 32'h40, 0, 3, 3), 0, 0, 0, 0, 1, 0, 32'h40};
      tab[3]  = '{mk(0,0,0,1,0, 0, 0, 32'h44, 0, 3, 4), 0, 0, 0, 0, 0, 0, 32'h44};
      tab[4]  = '{mk(0,0,1,0,0, 32'h80, 32'h11, 0, 0, 1, 5), 0, 0, 0, 0, 0, 0, 0};
      tab[5]  = '{mk(1,1,0,0,0, 32'h00, 0, 0, 4, 2, 6), 1, 32'h11, 1, 1, 0, 0, 0};
      tab[6]  = '{mk(0,0,1,0,0, 32'h04, 32'h22, 0, 0, 1, 7), 0, 0, 0, 0, 0, 0, 0};
      tab[7]  = '{mk(0,0,1,0,0, 32'h06, 32'h33, 0, 0, 1, 8), 0, 0, 0, 0, 0, ALIGN, 0};
      tab[8]  = '{mk(1,1,0,0,0, 32'h04, 0, 0, 5, 2, 9), 1, ALIGN ? 32'h22 : 32'h33, 1, 1, 0, 0, 0};
      tab[9]  = '{mk(1,1,0,0,0, 32'h05, 0, 0, 6, 2, 10), 1, ALIGN ? 32'h22 : 32'h33, !ALIGN, 1, 0, ALIGN, 0};
      tab[10] = '{mk(0,0,0,0,0, 0, 0, 0, 0, 0, 11), 1, 32'h11, 0, 0, 0, 0, 0};

      step();
      step();
      for (int d = 0; d < 2; d++)
         chk($sformatf("d%0d_reset", d),
             {o[d].wreg, o[d].m2reg, o[d].pcsrc, o[d].stall, o[d].err, o[d].destR, o[d].typ, o[d].num} |
             o[d].aluR | o[d].bpc, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         di[0] = tab[i].in;
         di[1] = '0;
         step();
         chk($sformatf("tab%0d_stall", i), {31'd0, o[0].stall}, 32'd0);
         chk($sformatf("tab%0d_flags", i), {28'd0, o[0].wreg, o[0].m2reg, o[0].pcsrc, o[0].err},
             {28'd0, tab[i].wreg, tab[i].m2reg, tab[i].pcsrc, tab[i].err});
         chk($sformatf("tab%0d_bpc", i), o[0].bpc, tab[i].bpc);
         if (tab[i].chk_md) chk($sformatf("tab%0d_mdata", i), o[0].mdata, tab[i].md);
      end
      di[0] = '0;

      // MEM_LAT=3: store then load to the same word, branch waiting behind the load
      di[1] = mk(0,0,1,0,0, 32'h08, 32'hDEADBEEF, 0, 0, 1, 2);
      step();
      chk("lat3_st_stall", {31'd0, o[1].stall}, 32'd1);
      di[1] = mk(1,1,0,0,0, 32'h08, 0, 0, 7, 5, 9);
      wait_done(n);
      chk("lat3_st_cycles", n, 3);
      step();
      di[1] = mk(0,0,0,1,1, 0, 0, 32'h40, 1, 6, 6);
      n = 0;
      for (int k = 0; k < 20 && o[1].stall; k++) begin
         chk("lat3_ld_hold", {19'd0, o[1].destR, o[1].typ, o[1].num}, {19'd0, 5'd7, 4'd5, 4'd9});
         n++;
         step();
      end
      chk("lat3_ld_cycles", n, 3);
      chk("lat3_ld_mdata", o[1].mdata, 32'hDEADBEEF);
      chk("lat3_ld_m2reg", {31'd0, o[1].m2reg}, 32'd1);
      step();
      chk("lat3_br", {o[1].stall, o[1].pcsrc, o[1].bpc[29:0]}, {1'b0, 1'b1, 30'h40});

      // reset in the first WAIT cycle drops the pending store
      di[1] = mk(0,0,1,0,0, 32'h04, 32'hA5, 0, 0, 1, 1);
      step();
      wait_done(n);
      di[1] = mk(0,0,1,0,0, 32'h04, 32'h5, 0, 0, 1, 2);
      step();
      di[1] = '0;
      step();
      rst = 1'b1;
      #1;
      chk("rst_stall_now", {31'd0, o[1].stall}, 32'd0);
      step();
      chk("rst_outs", {o[1].wreg, o[1].m2reg, o[1].pcsrc, o[1].stall, o[1].err, o[1].destR,
          o[1].typ, o[1].num} | o[1].aluR | o[1].bpc, 32'd0);
      rst = 1'b0;
      di[1] = mk(1,1,0,0,0, 32'h04, 0, 0, 2, 2, 3);
      step();
      di[1] = '0;
      wait_done(n);
      chk("rst_old_data", o[1].mdata, 32'hA5);

      for (int i = 0; i < 400; i++) begin
         di[0] = rnd();
         di[1] = rnd();
         rst = ($urandom_range(0, 49) == 0);
         step();
      end
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage pipelined MIPS CPU; consumes every EX-stage output.
- Contains the EX/MEM pipeline register, a word-addressed data RAM and branch resolution (pcsrc, target).
- A wait-state FSM models slow memory: it stalls the pipeline for a configurable number of cycles per load or store.
- Feeds the WB stage and the IF-stage PC mux.

Parameters:
- DEPTH_LOG2, 5: data RAM holds 2^DEPTH_LOG2 32-bit words.
- MEM_LAT, 0: extra wait cycles per load/store (0..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- ex_wreg  in  1  register-write enable from EX.
- ex_m2reg  in  1  load: writeback from memory.
- ex_wmem  in  1  store enable.
- ex_aluR  in  32  ALU result / byte address.
- ex_inB  in  32  store data.
- ex_destR  in  5  destination register.
- ex_branch  in  1  instruction is beq-type.
- ex_pc  in  32  branch target.
- ex_zero  in  1  operands equal.
- EXE_ins_type  in  4  instruction-tracking tag.
- EXE_ins_number  in  4  instruction-tracking tag.
- mem_wreg  out  1  registered wreg to WB.
- mem_m2reg  out  1  registered m2reg to WB.
- mem_aluR  out  32  registered ALU result.
- mem_mdata  out  32  RAM read data.
- mem_destR  out  5  registered destination.
- mem_pcsrc  out  1  branch taken.
- mem_bpc  out  32  registered branch target.
- mem_stall  out  1  freeze IF/ID/EX and the EX/MEM register.
- mem_addr_err  out  1  misaligned access flag.
- MEM_ins_type  out  4  registered tag.
- MEM_ins_number  out  4  registered tag.

Behaviour:
- Reset values (when rst=1 at an edge): every EX/MEM register field 0, so all outputs are 0; FSM goes to IDLE; wait counter 0; any pending store is dropped. RAM contents are not reset.
- EX/MEM register: loads all ex_* and EXE_* inputs at each edge where mem_stall=0. It holds when mem_stall=1, and inputs are ignored while stalled.
- Address: word index = mem_aluR[DEPTH_LOG2+1:2]. Upper address bits are ignored, so accesses wrap modulo the RAM size.
- mem_mdata: combinational read RAM[index]; meaningful only when mem_stall=0.
- Branch: mem_pcsrc = mem_branch & mem_zero, combinational from registered fields. mem_bpc = registered ex_pc. Flushing younger instructions is outside this block.
- FSM states: IDLE and WAIT.
  - IDLE: if the registered op is a load or store and MEM_LAT>0, then mem_stall=1, counter loads MEM_LAT-1 and the FSM moves to WAIT. Otherwise mem_stall=0.
  - WAIT: mem_stall=1 and the counter decrements each cycle. When counter=0, the next state is DONE-equivalent IDLE with mem_stall=0 for exactly one cycle, while the same op is still registered; this cycle completes the access.
  - The same op does not re-trigger a stall; a completion flag is cleared when the register next loads.
- Store timing: RAM[index] <= mem_inB at the edge ending the cycle in which a store is registered and mem_stall=0.
- Latency: a load result is visible on mem_mdata MEM_LAT cycles after capture; a store commits MEM_LAT+1 edges after capture.
- Back-to-back memory ops each take a full stall window. Non-memory ops never stall.
- Store and load to the same word in consecutive instructions: the load returns the new data.
- Reset asserted during WAIT: the stall ends immediately and the pending store is not written.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a load/store with mem_aluR[1:0]!=0 is misaligned.
  - Store write is suppressed.
  - Load has mem_wreg forced to 0.
  - mem_addr_err=1 for every cycle the op is registered.
  - No stall is generated for the misaligned op.
- Undefined: mem_aluR[1:0] is ignored and mem_addr_err is tied to 0.

Test Plan:
- MEM_LAT=0; store ex_aluR=0x08, ex_inB=0xDEADBEEF, then load 0x08 -> next cycle mem_mdata=0xDEADBEEF, mem_m2reg=1, mem_stall never 1.
- MEM_LAT=3; load captured -> mem_stall=1 for exactly 3 cycles, tags and mem_destR held, then mem_stall=0 for one cycle with valid mem_mdata; the next instruction is captured afterwards.
- ex_branch=1, ex_zero=1, ex_pc=0x40 -> mem_pcsrc=1, mem_bpc=0x40 one cycle later; with ex_zero=0 -> mem_pcsrc=0.
- DEPTH_LOG2=5; store 0x11 at address 0x80, load address 0x00 -> mem_mdata=0x11 (wrap).
- MEM_LAT=2; store 0x5 to 0x4, rst pulsed in the first WAIT cycle -> all outputs 0, stall cleared, a later load from 0x4 returns the old value.
- MEM_ALIGN_CHECK_EN defined; store to 0x06 -> mem_addr_err=1, RAM word 1 unchanged; undefined -> word 1 written, mem_addr_err=0.
